// File: rtl/ad5541a_spi_receiver.sv
// AD5541A SPI slave model: receives DAC frames over SPI, forwards each
// good frame on an AXI-stream port and models the LDAC-loaded DAC register.
module ad5541a_spi_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  input  logic                  ldac_n,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic [DATA_WIDTH-1:0] dac_code,
  output logic                  frame_err,
  output logic                  overrun,
  output logic [15:0]           frame_count
);

  localparam int CW = $clog2(DATA_WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    ARMED,
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  state_t state_q, state_d;

  // Bit SYNC_STAGES-1 is the synchronized value, bit SYNC_STAGES its delayed copy.
  logic [SYNC_STAGES:0]   sclk_sync;
  logic [SYNC_STAGES:0]   cs_sync;
  logic [SYNC_STAGES:0]   ldac_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES:0]   prime;

  logic sclk_rise, cs_fall, cs_rise, ldac_fall;
  logic cs_s, mosi_s, primed;

  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] last_word;
  logic [CW-1:0]         bit_cnt;

  logic clr_cnt, shift_en, accept, bad, drop;

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_sync[SYNC_STAGES];
  assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_sync[SYNC_STAGES];
  assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_sync[SYNC_STAGES];
  assign ldac_fall = ~ldac_sync[SYNC_STAGES-1] & ldac_sync[SYNC_STAGES];
  // The cs_n preset is not a real sample; wait until the chain is flushed.
  assign primed    = prime[SYNC_STAGES];

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      ldac_sync <= '1;
      mosi_sync <= '0;
      prime     <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-1:0], cs_n};
      ldac_sync <= {ldac_sync[SYNC_STAGES-1:0], ldac_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      prime     <= {prime[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state_q <= ARMED;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    clr_cnt  = 1'b0;
    shift_en = 1'b0;
    accept   = 1'b0;
    bad      = 1'b0;
    drop     = 1'b0;
    unique case (state_q)
      ARMED: if (primed && cs_s) state_d = IDLE;
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          clr_cnt = 1'b1;
        end
      end
      SHIFT: begin
        shift_en = sclk_rise;
        if (cs_rise) state_d = CHECK;
      end
      CHECK: begin
        state_d = IDLE;
        if (bit_cnt != CNT_FULL)                  bad    = 1'b1;
        else if (!m_axis_valid || m_axis_ready)   accept = 1'b1;
        else                                      drop   = 1'b1;
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      last_word    <= '0;
      frame_count  <= '0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      dac_code     <= '0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (clr_cnt) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        shreg <= {shreg[DATA_WIDTH-2:0], mosi_s};
        if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
      end
      frame_err <= bad;
      overrun   <= drop;
      if (accept) begin
        m_axis_data <= shreg;
        last_word   <= shreg;
        frame_count <= frame_count + 16'd1;
      end
      if (accept)            m_axis_valid <= 1'b1;
      else if (m_axis_ready) m_axis_valid <= 1'b0;
      if (ldac_fall) dac_code <= last_word;
    end
  end

endmodule
